// File: rtl/fir_pkg.sv
// Shared definitions for the FIR front end and core: default widths and the
// input controller's state encoding.
package fir_pkg;

  localparam int DEFAULT_DATA_W      = 8;
  localparam int DEFAULT_NUM_TAPS    = 4;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    STREAM    = 2'd0,
    LOAD      = 2'd1,
    LOAD_DONE = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/fir_input_ctrl_if.sv
// Pin-side and core-side signals of the FIR input controller.
// master = the pin/core environment, slave = the controller.
interface fir_input_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);

  logic [DATA_W-1:0] x_in;
  logic              tvalid_in;
  logic              set_coeffs_in;

  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              coeff_wr_en;
  logic [ADDR_W-1:0] coeff_wr_addr;
  logic [DATA_W-1:0] coeff_wr_data;
  logic              loading;
  logic              coeffs_loaded;

  modport master (
    output x_in, tvalid_in, set_coeffs_in,
    input  sample_out, sample_valid, coeff_wr_en, coeff_wr_addr,
           coeff_wr_data, loading, coeffs_loaded
  );

  modport slave (
    input  x_in, tvalid_in, set_coeffs_in,
    output sample_out, sample_valid, coeff_wr_en, coeff_wr_addr,
           coeff_wr_data, loading, coeffs_loaded
  );

endinterface

// File: rtl/fir_input_ctrl_sync.sv
// Multi-flop synchroniser for one asynchronous pin plus rise/fall detection.
// level appears SYNC_STAGES edges after the pin is first sampled; rise/fall last one cycle.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= '0;
      level_prev_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], async_in};
      level_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_prev_q;
  assign fall  = ~level & level_prev_q;

endmodule

// File: rtl/fir_input_ctrl.sv
// FIR input controller: turns raw async pin strobes into single-cycle sample
// or coefficient-write strobes and tracks coefficient-load sessions.
module fir_input_ctrl
  import fir_pkg::*;
#(
  parameter int NUM_TAPS    = DEFAULT_NUM_TAPS,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int ADDR_W      = $clog2(NUM_TAPS)
) (
  input logic              clk,
  input logic              reset,
  fir_input_ctrl_if.slave  pins
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAPS - 1);

  logic v_rise, v_fall_unused, v_level_unused;
  logic c_rise, c_fall, c_level_unused;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tvalid (
    .clk      (clk),
    .reset    (reset),
    .async_in (pins.tvalid_in),
    .level    (v_level_unused),
    .rise     (v_rise),
    .fall     (v_fall_unused)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_coeffs (
    .clk      (clk),
    .reset    (reset),
    .async_in (pins.set_coeffs_in),
    .level    (c_level_unused),
    .rise     (c_rise),
    .fall     (c_fall)
  );

  ctrl_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] sample_q;
  logic              sample_valid_q;
  logic              coeff_wr_en_q;
  logic [ADDR_W-1:0] coeff_wr_addr_q;
  logic [DATA_W-1:0] coeff_wr_data_q;
  logic              loading_q;
  logic              coeffs_loaded_q;

  // Mode edges take priority over a coincident word strobe, which is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= STREAM;
      addr_q          <= '0;
      sample_q        <= '0;
      sample_valid_q  <= 1'b0;
      coeff_wr_en_q   <= 1'b0;
      coeff_wr_addr_q <= '0;
      coeff_wr_data_q <= '0;
      loading_q       <= 1'b0;
      coeffs_loaded_q <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      coeff_wr_en_q  <= 1'b0;
      case (state_q)
        STREAM: begin
          if (c_rise) begin
            state_q         <= LOAD;
            addr_q          <= '0;
            coeffs_loaded_q <= 1'b0;
            loading_q       <= 1'b1;
          end else if (v_rise) begin
            sample_q       <= pins.x_in;
            sample_valid_q <= 1'b1;
          end
        end
        LOAD: begin
          if (c_fall) begin
            state_q   <= STREAM;
            addr_q    <= '0;
            loading_q <= 1'b0;
          end else if (v_rise) begin
            coeff_wr_en_q   <= 1'b1;
            coeff_wr_data_q <= pins.x_in;
            coeff_wr_addr_q <= addr_q;
            if (addr_q == LAST_ADDR) begin
              state_q         <= LOAD_DONE;
              coeffs_loaded_q <= 1'b1;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        LOAD_DONE: begin
          if (c_fall) begin
            state_q   <= STREAM;
            addr_q    <= '0;
            loading_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= STREAM;
          addr_q    <= '0;
          loading_q <= 1'b0;
        end
      endcase
    end
  end

  assign pins.sample_out    = sample_q;
  assign pins.sample_valid  = sample_valid_q;
  assign pins.coeff_wr_en   = coeff_wr_en_q;
  assign pins.coeff_wr_addr = coeff_wr_addr_q;
  assign pins.coeff_wr_data = coeff_wr_data_q;
  assign pins.loading       = loading_q;
  assign pins.coeffs_loaded = coeffs_loaded_q;

endmodule

// File: tb/tb_fir_input_ctrl.sv
// Directed bench for fir_input_ctrl: sample path, coefficient load, abort,
// simultaneous strobes and mid-load reset.
module tb_fir_input_ctrl;
  import fir_pkg::*;

  localparam int DW = 8;
  localparam int NT = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_input_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) pins();

  fir_input_ctrl #(.NUM_TAPS(NT), .DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .pins  (pins.slave)
  );

  int total = 0;
  int bad   = 0;
  int sv_cnt   = 0;
  int both_cnt = 0;
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];

  // Log strobes shortly after each active edge.
  always @(posedge clk) begin
    #1;
    if (pins.sample_valid) sv_cnt++;
    if (pins.coeff_wr_en) begin
      wa_q.push_back(pins.coeff_wr_addr);
      wd_q.push_back(pins.coeff_wr_data);
    end
    if (pins.sample_valid && pins.coeff_wr_en) both_cnt++;
  end

  task automatic clear_log();
    sv_cnt = 0;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    pins.x_in = d;
    pins.tvalid_in = 1'b1;
    wait_neg(4);
    pins.tvalid_in = 1'b0;
    wait_neg(4);
  endtask

  task automatic set_mode(input logic m);
    pins.set_coeffs_in = m;
    wait_neg(4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pins.x_in = '0;
    pins.tvalid_in = 1'b0;
    pins.set_coeffs_in = 1'b0;
    #1;
    total++; if (pins.sample_valid !== 1'b0) begin bad++; $display("FAIL rst_sv got=%b want=0", pins.sample_valid); end
    total++; if (pins.coeff_wr_en !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", pins.coeff_wr_en); end
    total++; if (pins.loading !== 1'b0) begin bad++; $display("FAIL rst_loading got=%b want=0", pins.loading); end
    total++; if (pins.coeffs_loaded !== 1'b0) begin bad++; $display("FAIL rst_loaded got=%b want=0", pins.coeffs_loaded); end
    total++; if (pins.sample_out !== 8'h00) begin bad++; $display("FAIL rst_sample got=%h want=00", pins.sample_out); end
    total++; if (pins.coeff_wr_addr !== 2'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", pins.coeff_wr_addr); end
    wait_neg(2);
    reset = 1'b0;
    wait_neg(2);
  endtask

  task automatic test_sample();
    clear_log();
    pins.x_in = 8'hA5;
    pins.tvalid_in = 1'b1;
    wait_neg(1);
    total++; if (pins.sample_valid !== 1'b0) begin bad++; $display("FAIL smp_e0 got=%b want=0", pins.sample_valid); end
    wait_neg(1);
    total++; if (pins.sample_valid !== 1'b0) begin bad++; $display("FAIL smp_e1 got=%b want=0", pins.sample_valid); end
    wait_neg(1);
    total++; if (pins.sample_valid !== 1'b1) begin bad++; $display("FAIL smp_e2 got=%b want=1", pins.sample_valid); end
    total++; if (pins.sample_out !== 8'hA5) begin bad++; $display("FAIL smp_data got=%h want=a5", pins.sample_out); end
    wait_neg(1);
    total++; if (pins.sample_valid !== 1'b0) begin bad++; $display("FAIL smp_e3 got=%b want=0", pins.sample_valid); end
    pins.tvalid_in = 1'b0;
    wait_neg(4);
    total++; if (sv_cnt != 1) begin bad++; $display("FAIL smp_count got=%0d want=1", sv_cnt); end
    total++; if (wa_q.size() != 0) begin bad++; $display("FAIL smp_no_we got=%0d want=0", wa_q.size()); end
    total++; if (pins.sample_out !== 8'hA5) begin bad++; $display("FAIL smp_hold got=%h want=a5", pins.sample_out); end
  endtask

  task automatic test_load();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    set_mode(1'b1);
    total++; if (pins.loading !== 1'b1) begin bad++; $display("FAIL ld_loading got=%b want=1", pins.loading); end
    clear_log();
    for (int i = 0; i < 3; i++) send_word(DW'(i + 1));
    total++; if (pins.coeffs_loaded !== 1'b0) begin bad++; $display("FAIL ld_early got=%b want=0", pins.coeffs_loaded); end
    send_word(8'h04);
    total++; if (wa_q.size() != 4) begin bad++; $display("FAIL ld_count got=%0d want=4", wa_q.size()); end
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      ea = AW'(i);
      ed = DW'(i + 1);
      total++; if (wa_q[i] !== ea || wd_q[i] !== ed) begin bad++; $display("FAIL ld_write%0d got=%0d/%h want=%0d/%h", i, wa_q[i], wd_q[i], ea, ed); end
    end
    total++; if (pins.coeffs_loaded !== 1'b1) begin bad++; $display("FAIL ld_loaded got=%b want=1", pins.coeffs_loaded); end
    total++; if (pins.loading !== 1'b1) begin bad++; $display("FAIL ld_loading2 got=%b want=1", pins.loading); end
    total++; if (sv_cnt != 0) begin bad++; $display("FAIL ld_no_sv got=%0d want=0", sv_cnt); end
  endtask

  task automatic test_load_done();
    clear_log();
    send_word(8'hFF);
    total++; if (wa_q.size() != 0) begin bad++; $display("FAIL done_no_we got=%0d want=0", wa_q.size()); end
    total++; if (sv_cnt != 0) begin bad++; $display("FAIL done_no_sv got=%0d want=0", sv_cnt); end
    total++; if (pins.coeff_wr_data !== 8'h04) begin bad++; $display("FAIL done_data_hold got=%h want=04", pins.coeff_wr_data); end
    total++; if (pins.coeff_wr_addr !== 2'd3) begin bad++; $display("FAIL done_addr_hold got=%0d want=3", pins.coeff_wr_addr); end
    pins.set_coeffs_in = 1'b0;
    wait_neg(2);
    total++; if (pins.loading !== 1'b1) begin bad++; $display("FAIL done_exit_early got=%b want=1", pins.loading); end
    wait_neg(1);
    total++; if (pins.loading !== 1'b0) begin bad++; $display("FAIL done_exit got=%b want=0", pins.loading); end
    wait_neg(1);
    clear_log();
    send_word(8'h3C);
    total++; if (sv_cnt != 1) begin bad++; $display("FAIL done_sv got=%0d want=1", sv_cnt); end
    total++; if (pins.sample_out !== 8'h3C) begin bad++; $display("FAIL done_sample got=%h want=3c", pins.sample_out); end
    total++; if (pins.coeffs_loaded !== 1'b1) begin bad++; $display("FAIL done_loaded_keep got=%b want=1", pins.coeffs_loaded); end
  endtask

  task automatic test_abort();
    set_mode(1'b1);
    total++; if (pins.coeffs_loaded !== 1'b0) begin bad++; $display("FAIL ab_clear got=%b want=0", pins.coeffs_loaded); end
    clear_log();
    send_word(8'h11);
    send_word(8'h22);
    set_mode(1'b0);
    total++; if (wa_q.size() != 2) begin bad++; $display("FAIL ab_count got=%0d want=2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      total++; if (wa_q[0] !== 2'd0 || wd_q[0] !== 8'h11) begin bad++; $display("FAIL ab_w0 got=%0d/%h want=0/11", wa_q[0], wd_q[0]); end
      total++; if (wa_q[1] !== 2'd1 || wd_q[1] !== 8'h22) begin bad++; $display("FAIL ab_w1 got=%0d/%h want=1/22", wa_q[1], wd_q[1]); end
    end
    total++; if (pins.coeffs_loaded !== 1'b0) begin bad++; $display("FAIL ab_loaded got=%b want=0", pins.coeffs_loaded); end
    total++; if (pins.loading !== 1'b0) begin bad++; $display("FAIL ab_loading got=%b want=0", pins.loading); end
    clear_log();
    send_word(8'h44);
    total++; if (sv_cnt != 1 || pins.sample_out !== 8'h44) begin bad++; $display("FAIL ab_stream got=%0d/%h want=1/44", sv_cnt, pins.sample_out); end
    set_mode(1'b1);
    clear_log();
    send_word(8'h33);
    total++; if (wa_q.size() != 1 || wa_q[0] !== 2'd0 || wd_q[0] !== 8'h33) begin bad++; $display("FAIL ab_restart got=n%0d want=1 write at 0/33", wa_q.size()); end
    set_mode(1'b0);
  endtask

  task automatic test_simultaneous();
    clear_log();
    pins.x_in = 8'h5E;
    pins.tvalid_in = 1'b1;
    pins.set_coeffs_in = 1'b1;
    wait_neg(4);
    pins.tvalid_in = 1'b0;
    wait_neg(4);
    total++; if (sv_cnt != 0) begin bad++; $display("FAIL sim_no_sv got=%0d want=0", sv_cnt); end
    total++; if (wa_q.size() != 0) begin bad++; $display("FAIL sim_no_we got=%0d want=0", wa_q.size()); end
    total++; if (pins.loading !== 1'b1) begin bad++; $display("FAIL sim_loading got=%b want=1", pins.loading); end
    clear_log();
    send_word(8'h66);
    total++; if (wa_q.size() != 1 || wa_q[0] !== 2'd0 || wd_q[0] !== 8'h66) begin bad++; $display("FAIL sim_first_write got=n%0d want=1 write at 0/66", wa_q.size()); end
    set_mode(1'b0);
  endtask

  task automatic test_reset_mid_load();
    set_mode(1'b1);
    clear_log();
    send_word(8'hA1);
    send_word(8'hB2);
    total++; if (wa_q.size() != 2) begin bad++; $display("FAIL rm_pre got=%0d want=2", wa_q.size()); end
    reset = 1'b1;
    #1;
    total++; if (pins.loading !== 1'b0) begin bad++; $display("FAIL rm_loading got=%b want=0", pins.loading); end
    total++; if (pins.coeff_wr_addr !== 2'd0) begin bad++; $display("FAIL rm_addr got=%0d want=0", pins.coeff_wr_addr); end
    total++; if (pins.coeff_wr_data !== 8'h00) begin bad++; $display("FAIL rm_data got=%h want=00", pins.coeff_wr_data); end
    total++; if (pins.sample_out !== 8'h00) begin bad++; $display("FAIL rm_sample got=%h want=00", pins.sample_out); end
    total++; if (pins.coeffs_loaded !== 1'b0) begin bad++; $display("FAIL rm_loaded got=%b want=0", pins.coeffs_loaded); end
    pins.set_coeffs_in = 1'b0;
    wait_neg(2);
    reset = 1'b0;
    wait_neg(2);
    clear_log();
    send_word(8'h5A);
    total++; if (sv_cnt != 1 || pins.sample_out !== 8'h5A) begin bad++; $display("FAIL rm_sample_after got=%0d/%h want=1/5a", sv_cnt, pins.sample_out); end
    set_mode(1'b1);
    clear_log();
    send_word(8'h77);
    total++; if (wa_q.size() != 1 || wa_q[0] !== 2'd0 || wd_q[0] !== 8'h77) begin bad++; $display("FAIL rm_reload got=n%0d want=1 write at 0/77", wa_q.size()); end
    set_mode(1'b0);
  endtask

  initial begin
    test_reset();
    test_sample();
    test_load();
    test_load_done();
    test_abort();
    test_simultaneous();
    test_reset_mid_load();
    total++; if (both_cnt != 0) begin bad++; $display("FAIL sv_we_overlap got=%0d want=0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
